// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: FSM state encodings and default bank read latency shared with ram_group integration.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rsr_state_t;

    localparam int RAM_READ_LATENCY = 3;

endpackage

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: first-word-fall-through synchronous FIFO with occupancy count.
module ram_rd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             full;

    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sequential bank reader with credit-controlled FIFO feeding a valid/ready stream.
// Define RAM_STREAM_READER_STATS_EN to add saturating beat and stall counters.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int AWIDTH       = 10,
    parameter int DWIDTH       = 64,
    parameter int READ_LATENCY = RAM_READ_LATENCY,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    output logic              ram_ce,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_q,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DWIDTH-1:0] dout_data,
    output logic              dout_last,
`ifdef RAM_STREAM_READER_STATS_EN
    output logic              busy,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_stall
`else
    output logic              busy
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    rsr_state_t              state, state_nx;
    logic [AWIDTH-1:0]       cur_addr;
    logic [AWIDTH:0]         remaining;
    logic [READ_LATENCY-1:0] pv, pl;
    logic [CW-1:0]           count, inflight;
    logic [CW:0]             used;
    logic                    credit_ok, issue, last_issue, accept, pop, empty;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pv[i]);
    end

    // Buffered plus in-flight words may never exceed the FIFO, so every return has a slot.
    assign used       = {1'b0, count} + {1'b0, inflight};
    assign credit_ok  = used < (CW+1)'(FIFO_DEPTH);
    assign issue      = state == ISSUE && credit_ok;
    assign last_issue = issue && remaining == (AWIDTH+1)'(1);
    assign cmd_ready  = state == IDLE;
    assign accept     = cmd_valid && cmd_ready;
    assign ram_ce     = issue;
    assign ram_addr   = cur_addr;
    assign ram_d      = '0;
    assign ram_we     = 1'b0;
    assign dout_valid = !empty;
    assign pop        = dout_valid && dout_ready;
    assign busy       = state != IDLE || !empty;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && accept && cmd_len != '0) ? ISSUE :
                   (state == ISSUE && last_issue)             ? DRAIN :
                   (state == DRAIN && inflight == '0)         ? IDLE  : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            pv        <= '0;
            pl        <= '0;
        end else begin
            state <= state_nx;
            pv    <= (pv << 1) | READ_LATENCY'(issue);
            pl    <= (pl << 1) | READ_LATENCY'(last_issue);
            if (accept) begin
                cur_addr  <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue) begin
                cur_addr  <= cur_addr + AWIDTH'(1);
                remaining <= remaining - (AWIDTH+1)'(1);
            end
        end
    end

    ram_rd_fifo #(
        .WIDTH(DWIDTH+1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (pv[READ_LATENCY-1]),
        .din  ({pl[READ_LATENCY-1], ram_q}),
        .pop  (pop),
        .dout ({dout_last, dout_data}),
        .count(count),
        .empty(empty)
    );

`ifdef RAM_STREAM_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            if (pop && !(&stat_beats)) stat_beats <= stat_beats + 32'd1;
            if (state == ISSUE && !credit_ok && !(&stat_stall)) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized self-checking bench with a bank model and a per-command expected-stream model.
module tb_ram_stream_reader;
    logic        clk = 0;
    logic        rst = 1;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [9:0]  cmd_addr = '0;
    logic [10:0] cmd_len = '0;
    logic [9:0]  ram_addr;
    logic [63:0] ram_d;
    logic        ram_ce;
    logic        ram_we;
    logic [63:0] ram_q, q1, q2;
    logic        dout_valid;
    logic        dout_ready = 0;
    logic [63:0] dout_data;
    logic        dout_last;
    logic        busy;
`ifdef RAM_STREAM_READER_STATS_EN
    logic [31:0] stat_beats, stat_stall;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc, first_valid;
    logic [63:0] mem [1024];
    logic [64:0] got_q[$], exp_q[$];
    logic [9:0]  ce_addr_q[$];
    int          ce_cyc_q[$], beat_cyc_q[$];
    logic        hold, hl;
    logic [63:0] hd;

    ram_stream_reader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_ce(ram_ce), .ram_we(ram_we), .ram_q(ram_q),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
`ifdef RAM_STREAM_READER_STATS_EN
        .busy(busy), .stat_beats(stat_beats), .stat_stall(stat_stall)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        q1 <= mem[ram_addr];
        q2 <= q1;
        ram_q <= q2;
    end

    always @(negedge clk) begin
        if (rst) hold = 0;
        else begin
            if (hold) begin
                tests++;
                if (!dout_valid || dout_data !== hd || dout_last !== hl) begin
                    fails++;
                    $display("FAIL stall_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b", dout_valid, dout_data, dout_last, hd, hl);
                end
            end
            hold = dout_valid && !dout_ready;
            hd = dout_data;
            hl = dout_last;
            if (dout_valid && dout_ready) begin
                got_q.push_back({dout_last, dout_data});
                beat_cyc_q.push_back(cyc);
            end
            if (ram_ce) begin
                ce_addr_q.push_back(ram_addr);
                ce_cyc_q.push_back(cyc);
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (dout_valid && first_valid < 0) first_valid = cyc;
        end
    end

    task automatic clear_logs();
        got_q.delete(); exp_q.delete(); ce_addr_q.delete(); ce_cyc_q.delete(); beat_cyc_q.delete();
        first_valid = -1;
        acc_cyc = -1;
    endtask

    task automatic send_cmd(input logic [9:0] a, input logic [10:0] l);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_addr = a; cmd_len = l;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 2000);
        if (!cmd_ready) begin
            tests++; fails++;
            $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        cmd_valid = 0;
        for (int i = 0; i < int'(l); i++) exp_q.push_back({1'(i == int'(l) - 1), mem[10'(int'(a) + i)]});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 3000);
        if (busy) begin
            tests++; fails++;
            $display("FAIL %s_idle: busy=1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic check_stream(input string name);
        bit bad = got_q.size() != exp_q.size();
        foreach (exp_q[i]) if (!bad && got_q[i] !== exp_q[i]) bad = 1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s_data: got %0d beats (first %h), required %0d beats (first %h)", name, got_q.size(),
                     got_q.size() ? got_q[0] : 65'h0, exp_q.size(), exp_q.size() ? exp_q[0] : 65'h0);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        tests++;
        if ({cmd_ready, dout_valid, busy, ram_ce, ram_we, ram_addr, ram_d} !== {1'b1, 4'b0, 10'h0, 64'h0}) begin
            fails++;
            $display("FAIL reset: ready=%b valid=%b busy=%b ce=%b we=%b addr=%h d=%h, required 1 0 0 0 0 000 0",
                     cmd_ready, dout_valid, busy, ram_ce, ram_we, ram_addr, ram_d);
        end
    endtask

    task automatic test_basic();
        foreach (mem[i]) mem[i] = 64'(i);
        clear_logs();
        dout_ready = 1;
        send_cmd(10'h010, 11'd4);
        wait_idle("basic");
        check_stream("basic");
        tests++;
        if (ce_cyc_q.size() != 4 || ce_cyc_q[0] - acc_cyc != 1 || ce_cyc_q[3] - ce_cyc_q[0] != 3) begin
            fails++;
            $display("FAIL basic_ce: %0d pulses, first at +%0d, required 4 consecutive at +1", ce_cyc_q.size(),
                     ce_cyc_q.size() ? ce_cyc_q[0] - acc_cyc : -1);
        end
        tests++;
        if (first_valid - acc_cyc != 5) begin
            fails++;
            $display("FAIL basic_latency: first dout_valid at +%0d, required +5", first_valid - acc_cyc);
        end
        tests++;
        if (beat_cyc_q.size() != 4 || beat_cyc_q[3] - beat_cyc_q[0] != 3) begin
            fails++;
            $display("FAIL basic_throughput: %0d beats, not back-to-back, required 4 consecutive", beat_cyc_q.size());
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        send_cmd(10'h3FE, 11'd4);
        wait_idle("wrap");
        check_stream("wrap");
        tests++;
        if (ce_addr_q.size() != 4 || ce_addr_q[0] != 10'h3FE || ce_addr_q[1] != 10'h3FF ||
            ce_addr_q[2] != 10'h000 || ce_addr_q[3] != 10'h001) begin
            fails++;
            $display("FAIL wrap_addr: %0d addresses (first %h), required 3fe 3ff 000 001", ce_addr_q.size(),
                     ce_addr_q.size() ? ce_addr_q[0] : 10'h0);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        dout_ready = 0;
        send_cmd(10'(32'($urandom)), 11'd32);
        repeat (30) @(negedge clk);
        tests++;
        if (ce_addr_q.size() != 8 || ram_ce !== 1'b0 || dout_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_credit: %0d pulses ce=%b valid=%b, required 8 pulses ce=0 valid=1", ce_addr_q.size(), ram_ce, dout_valid);
        end
        @(posedge clk); #1 dout_ready = 1;
        wait_idle("bp");
        check_stream("bp");
    endtask

    task automatic test_random_ready();
        int n = 0;
        foreach (mem[i]) mem[i] = {32'($urandom), 32'($urandom)};
        clear_logs();
        dout_ready = 1'($urandom);
        send_cmd(10'(32'($urandom)), 11'd100);
        do begin
            @(posedge clk); #1 dout_ready = 1'($urandom);
            @(negedge clk); n++;
        end while (busy && n < 3000);
        dout_ready = 1;
        wait_idle("rand");
        check_stream("rand");
    endtask

    task automatic test_back_to_back();
        clear_logs();
        dout_ready = 1;
        send_cmd(10'(32'($urandom)), 11'($urandom_range(1, 20)));
        send_cmd(10'(32'($urandom)), 11'($urandom_range(1, 20)));
        send_cmd(10'(32'($urandom)), 11'd1024);
        wait_idle("b2b");
        check_stream("b2b");
    endtask

    task automatic test_reset_mid();
        clear_logs();
        dout_ready = 1;
        send_cmd(10'h100, 11'd20);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        got_q.delete();
        @(negedge clk);
        tests++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: valid=%b busy=%b ready=%b, required 0 0 1", dout_valid, busy, cmd_ready);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL rst_stale: %0d beats after reset, required 0", got_q.size());
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        send_cmd(10'h0AA, 11'd0);
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_len: ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
        send_cmd(10'h005, 11'd1);
        wait_idle("len1");
        check_stream("len1");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_random_ready();
        test_back_to_back();
        test_reset_mid();
        test_zero_len();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
